aib_hrdrst_sl_rx: RTL
=====================

# aib_hrdrst_sl_rx

Slave-side receive half of the AIB hard-reset handshake. It is the counterpart to the master-to-slave sequencer. It waits for the master's `c_ms_tx_dcd_cal_done`, enables and settles the local RX DLL, and waits for lock, retrying on timeout. It then drives `c_sl_rx_dll_lock` and `c_sl_rx_transfer_en` back to the master and waits for `c_ms_tx_transfer_en`. It runs on the aux clock and sits between the slave-side reset controller (`i_start`/`o_done`) and the AIB RX DLL and channel sideband.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flop depth of the synchronizers on all asynchronous inputs (≥2).
- `SETTLE_CYCLES`, 16: DLL enable-settle and disable-hold duration in aux cycles (≥1).
- `LOCK_TIMEOUT`, 1024: maximum aux cycles spent waiting for DLL lock per attempt (≥1).
- `MAX_RETRY`, 3: number of re-attempts after the first lock timeout before failing (≥0).

Ports:
- `i_aux_clk`  in  1  aux clock; the block's only clock.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_start`  in  1  begin sequence; synchronous to `i_aux_clk`; level sampled only in IDLE.
- `o_done`  out  1  sequence complete (READY).
- `o_fail`  out  1  sticky; all lock attempts exhausted.
- `o_lock_lost`  out  1  sticky; DLL lock dropped after it was reported.
- `o_dll_en`  out  1  RX DLL enable.
- `i_dll_lock`  in  1  RX DLL lock; asynchronous, synchronized internally.
- `c_ms_tx_dcd_cal_done`  in  1  from master; asynchronous, synchronized internally.
- `c_ms_tx_transfer_en`  in  1  from master; asynchronous, synchronized internally.
- `c_sl_rx_dll_lock`  out  1  to master.
- `c_sl_rx_transfer_en`  out  1  to master.

## Operation
- Async inputs (`i_dll_lock`, `c_ms_tx_dcd_cal_done`, `c_ms_tx_transfer_en`) each pass through a `SYNC_STAGES`-flop synchronizer; the FSM sees only the synchronized copies.
- One down-counter of width `$clog2(max(SETTLE_CYCLES,LOCK_TIMEOUT)+1)` is shared by all timed states.
- The retry counter has width `$clog2(MAX_RETRY+1)+1` and saturates at `MAX_RETRY`.
- FSM states:
  - IDLE: `i_start`=1 → WAIT_DCD.
  - WAIT_DCD: synced dcd_cal_done=1 → DLL_SETTLE, counter ← `SETTLE_CYCLES`-1.
  - DLL_SETTLE: `o_dll_en`=1; counter=0 → WAIT_LOCK, counter ← `LOCK_TIMEOUT`-1; otherwise decrement.
  - WAIT_LOCK: `o_dll_en`=1.
    - Synced lock=1 → LOCKED. Lock wins over timeout in the same cycle.
    - Else counter=0 and retry<`MAX_RETRY` → retry++, DLL_OFF, counter ← `SETTLE_CYCLES`-1.
    - Else counter=0 → FAIL.
    - Else decrement.
  - DLL_OFF: `o_dll_en`=0; counter=0 → DLL_SETTLE, counter ← `SETTLE_CYCLES`-1.
  - LOCKED: `o_dll_en`=1, `c_sl_rx_dll_lock`=1; → XFER unconditionally.
  - XFER: `o_dll_en`, `c_sl_rx_dll_lock`, `c_sl_rx_transfer_en`=1; synced ms transfer_en=1 → READY.
  - READY: all three above =1, `o_done`=1; terminal until reset.
  - FAIL: `o_fail`=1, all other outputs 0; terminal until reset.
- Lock loss: in LOCKED, XFER or READY, synced lock=0 sets `o_lock_lost`=1. State and other outputs are unchanged; recovery is via reset only.
- `i_start` is ignored outside IDLE. Master inputs deasserting after being consumed are ignored.
- All outputs are Moore-decoded from registered state or sticky flops; none is combinational from inputs.

## Timing
- Reset: state IDLE, counters 0, synchronizers 0, all outputs 0 (`o_done`, `o_fail`, `o_lock_lost`, `o_dll_en`, `c_sl_rx_dll_lock`, `c_sl_rx_transfer_en`).
- Reset asserted mid-sequence returns to IDLE asynchronously and clears all outputs immediately.
- `i_start` high at edge n → WAIT_DCD after edge n.
- An async input rising before edge k causes the FSM transition at edge k+`SYNC_STAGES` (k+2 by default).
- DLL_SETTLE and DLL_OFF each last exactly `SETTLE_CYCLES` cycles.
- WAIT_LOCK lasts at most `LOCK_TIMEOUT` cycles per attempt.
- LOCKED lasts exactly 1 cycle, so `c_sl_rx_dll_lock` leads `c_sl_rx_transfer_en` by 1 cycle.
- Worst case to FAIL after DCD seen: (`MAX_RETRY`+1)·(`SETTLE_CYCLES`+`LOCK_TIMEOUT`) + `MAX_RETRY`·`SETTLE_CYCLES` cycles.

## Test plan
Default parameters unless noted.
- Nominal flow:
  - Stimulus: start; dcd_done 5 cycles later; lock 10 cycles after `o_dll_en` rises; ms transfer_en 4 cycles after `c_sl_rx_transfer_en`.
  - Required: `o_dll_en` rises 2 cycles after dcd_done; DLL_SETTLE lasts 16 cycles; `c_sl_rx_dll_lock` rises 1 cycle before `c_sl_rx_transfer_en`; `o_done` rises 2 cycles after ms transfer_en.
- Single timeout then lock (`LOCK_TIMEOUT`=8):
  - Stimulus: no lock on the first attempt; lock during the second attempt.
  - Required: `o_dll_en` low for exactly 16 cycles, then high again; exactly one retry; reaches READY; `o_fail`=0.
- Exhausted retries (`LOCK_TIMEOUT`=8, `MAX_RETRY`=2):
  - Stimulus: lock never asserts.
  - Required: three enable windows; `o_fail`=1 at cycle 16·3+8·3+16·2=104 after dcd seen; `o_dll_en`=0; FSM stays in FAIL.
- Lock and timeout coincide:
  - Stimulus: synced lock rises on the cycle the counter hits 0.
  - Required: LOCKED is taken, no retry.
- Lock loss in READY:
  - Stimulus: drop lock.
  - Required: `o_lock_lost`=1 after 2 cycles; `o_done`, `c_sl_rx_transfer_en` stay 1.
- Mid-sequence reset:
  - Stimulus: assert `i_rst` in WAIT_LOCK.
  - Required: all outputs 0 immediately; a fresh `i_start` reruns the nominal flow.

Source files
------------

// File: rtl/aib_hrdrst_sl_rx.sv
// rtl/aib_hrdrst_sl_rx.sv - slave-side RX half of the AIB hard-reset handshake
module aib_hrdrst_sl_rx #(
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 16,
    parameter int LOCK_TIMEOUT  = 1024,
    parameter int MAX_RETRY     = 3
) (
    input  logic i_aux_clk,
    input  logic i_rst,
    input  logic i_start,
    output logic o_done,
    output logic o_fail,
    output logic o_lock_lost,
    output logic o_dll_en,
    input  logic i_dll_lock,
    input  logic c_ms_tx_dcd_cal_done,
    input  logic c_ms_tx_transfer_en,
    output logic c_sl_rx_dll_lock,
    output logic c_sl_rx_transfer_en
);

    localparam int CNT_MAX = (SETTLE_CYCLES > LOCK_TIMEOUT) ? SETTLE_CYCLES : LOCK_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int RW      = $clog2(MAX_RETRY + 1) + 1;

    localparam logic [CW-1:0] SETTLE_LOAD  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(LOCK_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRY);

    typedef enum logic [3:0] {
        IDLE,
        WAIT_DCD,
        DLL_SETTLE,
        WAIT_LOCK,
        DLL_OFF,
        LOCKED,
        XFER,
        READY,
        FAIL
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [RW-1:0]   retry, retry_n;
    logic            lost_n;
    logic            en_n, sl_lock_n, sl_xfer_n, done_n, fail_n;

    logic [SYNC_STAGES-1:0] lock_sync, dcd_sync, xfer_sync;
    logic                   lock_s, dcd_s, xfer_s;

    always_ff @(posedge i_aux_clk or posedge i_rst) begin
        if (i_rst) begin
            lock_sync <= '0;
            dcd_sync  <= '0;
            xfer_sync <= '0;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], i_dll_lock};
            dcd_sync  <= {dcd_sync[SYNC_STAGES-2:0], c_ms_tx_dcd_cal_done};
            xfer_sync <= {xfer_sync[SYNC_STAGES-2:0], c_ms_tx_transfer_en};
        end
    end

    assign lock_s = lock_sync[SYNC_STAGES-1];
    assign dcd_s  = dcd_sync[SYNC_STAGES-1];
    assign xfer_s = xfer_sync[SYNC_STAGES-1];

    always_ff @(posedge i_aux_clk or posedge i_rst) begin
        if (i_rst) begin
            state               <= IDLE;
            cnt                 <= '0;
            retry               <= '0;
            o_lock_lost         <= 1'b0;
            o_dll_en            <= 1'b0;
            c_sl_rx_dll_lock    <= 1'b0;
            c_sl_rx_transfer_en <= 1'b0;
            o_done              <= 1'b0;
            o_fail              <= 1'b0;
        end else begin
            state               <= state_n;
            cnt                 <= cnt_n;
            retry               <= retry_n;
            o_lock_lost         <= lost_n;
            o_dll_en            <= en_n;
            c_sl_rx_dll_lock    <= sl_lock_n;
            c_sl_rx_transfer_en <= sl_xfer_n;
            o_done              <= done_n;
            o_fail              <= fail_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        retry_n = retry;
        lost_n  = o_lock_lost;
        case (state)
            IDLE: begin
                if (i_start) state_n = WAIT_DCD;
            end
            WAIT_DCD: begin
                if (dcd_s) begin
                    state_n = DLL_SETTLE;
                    cnt_n   = SETTLE_LOAD;
                end
            end
            DLL_SETTLE: begin
                if (cnt == '0) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = TIMEOUT_LOAD;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            WAIT_LOCK: begin
                // a lock seen on the timeout cycle still counts as success
                if (lock_s) begin
                    state_n = LOCKED;
                end else if (cnt == '0) begin
                    if (retry < RETRY_MAX) begin
                        retry_n = retry + RW'(1);
                        state_n = DLL_OFF;
                        cnt_n   = SETTLE_LOAD;
                    end else begin
                        state_n = FAIL;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            DLL_OFF: begin
                if (cnt == '0) begin
                    state_n = DLL_SETTLE;
                    cnt_n   = SETTLE_LOAD;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            LOCKED: state_n = XFER;
            XFER: begin
                if (xfer_s) state_n = READY;
            end
            READY: state_n = READY;
            FAIL:  state_n = FAIL;
            default: state_n = IDLE;
        endcase
        if ((state == LOCKED || state == XFER || state == READY) && !lock_s) lost_n = 1'b1;
    end

    // outputs decoded from the next state and registered, so sideband lines never glitch
    always_comb begin
        en_n      = 1'b0;
        sl_lock_n = 1'b0;
        sl_xfer_n = 1'b0;
        done_n    = 1'b0;
        fail_n    = 1'b0;
        case (state_n)
            DLL_SETTLE, WAIT_LOCK: en_n = 1'b1;
            LOCKED: begin
                en_n      = 1'b1;
                sl_lock_n = 1'b1;
            end
            XFER: begin
                en_n      = 1'b1;
                sl_lock_n = 1'b1;
                sl_xfer_n = 1'b1;
            end
            READY: begin
                en_n      = 1'b1;
                sl_lock_n = 1'b1;
                sl_xfer_n = 1'b1;
                done_n    = 1'b1;
            end
            FAIL: fail_n = 1'b1;
            default: en_n = 1'b0;
        endcase
    end

endmodule
